// File: rtl/uart_flash_cmd_ctrl.sv
// Frames the UART RX byte stream into flash-dump read commands (OP, A2..A0, L1, L0, CS)
// and presents each validated {address, length} to the flash reader over valid/ready.
module uart_flash_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 2700000,
  parameter logic [7:0]  OPCODE_READ    = 8'h52
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byteReady,
  input  logic [7:0]  dataIn,
  output logic        cmdValid,
  input  logic        cmdReady,
  output logic [23:0] cmdAddr,
  output logic [15:0] cmdLen,
  output logic        errValid,
  output logic [2:0]  errCode,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ADDR, LEN, CSUM, ISSUE} state_t;

  typedef enum logic [2:0] {
    ERR_OPCODE  = 3'd1,
    ERR_CSUM    = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_ZERO    = 3'd4,
    ERR_OVERRUN = 3'd5
  } err_t;

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, stateNext;
  logic          byteReadyPrev;
  logic [1:0]    byteIdx;
  logic [7:0]    xorAcc;
  logic [23:0]   addrSh;
  logic [15:0]   lenSh;
  logic [TW-1:0] timer;

  logic newByte, counting, timedOut, csumBad, lenZero;

  assign newByte  = byteReady & ~byteReadyPrev;
  assign counting = (state == ADDR) || (state == LEN) || (state == CSUM);
  // A byte edge in the expiry cycle beats the timeout.
  assign timedOut = counting && !newByte && (timer == TIMER_LAST);
  assign csumBad  = (dataIn != xorAcc);
  assign lenZero  = (lenSh == 16'd0);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path through the case leaves stateNext unassigned (no latch).
    stateNext = state;
    unique case (state)
      IDLE:  if (newByte && dataIn == OPCODE_READ) stateNext = ADDR;
      ADDR:  if (newByte && byteIdx == 2'd2)       stateNext = LEN;
             else if (timedOut)                    stateNext = IDLE;
      LEN:   if (newByte && byteIdx == 2'd1)       stateNext = CSUM;
             else if (timedOut)                    stateNext = IDLE;
      CSUM:  if (newByte)                          stateNext = (csumBad || lenZero) ? IDLE : ISSUE;
             else if (timedOut)                    stateNext = IDLE;
      ISSUE: if (cmdReady)                         stateNext = IDLE;
      default:                                     stateNext = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    cmdValid = (state == ISSUE);
    busy     = (state != IDLE);
  end

  // Datapath: edge detect, shadows, checksum, timeout and error reporting
  always_ff @(posedge clk) begin
    if (reset) begin
      byteReadyPrev <= 1'b1;  // a level already high at reset is not a new byte
      byteIdx       <= '0;
      xorAcc        <= '0;
      addrSh        <= '0;
      lenSh         <= '0;
      timer         <= '0;
      cmdAddr       <= '0;
      cmdLen        <= '0;
      errValid      <= 1'b0;
      errCode       <= '0;
    end else begin
      byteReadyPrev <= byteReady;
      errValid      <= 1'b0;

      if (newByte || !counting || timedOut) timer <= '0;
      else                                  timer <= timer + TW'(1);

      if (timedOut) begin
        errValid <= 1'b1;
        errCode  <= ERR_TIMEOUT;
        byteIdx  <= '0;
        xorAcc   <= '0;
        addrSh   <= '0;
        lenSh    <= '0;
      end else if (newByte) begin
        unique case (state)
          IDLE: begin
            if (dataIn == OPCODE_READ) begin
              xorAcc  <= dataIn;
              byteIdx <= '0;
              addrSh  <= '0;
              lenSh   <= '0;
            end else begin
              errValid <= 1'b1;
              errCode  <= ERR_OPCODE;
            end
          end
          ADDR: begin
            addrSh  <= {addrSh[15:0], dataIn};
            xorAcc  <= xorAcc ^ dataIn;
            byteIdx <= (byteIdx == 2'd2) ? 2'd0 : byteIdx + 2'd1;
          end
          LEN: begin
            lenSh   <= {lenSh[7:0], dataIn};
            xorAcc  <= xorAcc ^ dataIn;
            byteIdx <= (byteIdx == 2'd1) ? 2'd0 : byteIdx + 2'd1;
          end
          CSUM: begin
            if (csumBad) begin
              errValid <= 1'b1;
              errCode  <= ERR_CSUM;
            end else if (lenZero) begin
              errValid <= 1'b1;
              errCode  <= ERR_ZERO;
            end else begin
              cmdAddr <= addrSh;
              cmdLen  <= lenSh;
            end
          end
          ISSUE: begin
            // Byte is dropped; the pending command stays intact.
            errValid <= 1'b1;
            errCode  <= ERR_OVERRUN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_flash_cmd_ctrl.sv
// Scoreboard bench for uart_flash_cmd_ctrl: stimulus pushes expected commands/errors,
// a negedge monitor pops and compares whenever the DUT presents errValid or cmdValid.
module tb_uart_flash_cmd_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        byteReady;
  logic [7:0]  dataIn;
  logic        cmdValid;
  logic        cmdReady;
  logic [23:0] cmdAddr;
  logic [15:0] cmdLen;
  logic        errValid;
  logic [2:0]  errCode;
  logic        busy;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] len;
  } cmd_t;

  cmd_t       cmdQ[$];
  logic [2:0] errQ[$];
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_flash_cmd_ctrl #(.TIMEOUT_CYCLES(100), .OPCODE_READ(8'h52)) dut (
    .clk      (clk),
    .reset    (reset),
    .byteReady(byteReady),
    .dataIn   (dataIn),
    .cmdValid (cmdValid),
    .cmdReady (cmdReady),
    .cmdAddr  (cmdAddr),
    .cmdLen   (cmdLen),
    .errValid (errValid),
    .errCode  (errCode),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reportUnexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: output presented with nothing expected (errCode=%0d cmdAddr=%0h cmdLen=%0h)",
             name, errCode, cmdAddr, cmdLen);
  endtask

  // Monitor: errors and commands are checked against their own queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (errValid) begin
        if (errQ.size() == 0) reportUnexpected("unexpected_err");
        else                  check("errCode", {37'd0, errCode}, {37'd0, errQ.pop_front()});
      end
      if (cmdValid) begin
        if (cmdQ.size() == 0) reportUnexpected("unexpected_cmd");
        else begin
          check("cmd_addr_len", {cmdAddr, cmdLen}, {cmdQ[0].addr, cmdQ[0].len});
          if (cmdReady) void'(cmdQ.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Raise byteReady with a new byte; returns just after the edge-detect clock.
  task automatic sendRaw(input logic [7:0] b);
    @(posedge clk); #1;
    dataIn    = b;
    byteReady = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic dropByte();
    repeat (2) @(posedge clk);
    #1 byteReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    sendRaw(b);
    dropByte();
  endtask

  task automatic sendFrame(input logic [55:0] frame);
    for (int i = 0; i < 7; i++) sendByte(frame[55-8*i -: 8]);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy || cmdValid) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {39'd0, busy}, 40'd0);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    byteReady = 1'b0;
    dataIn    = 8'h00;
    cmdReady  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmdValid", {39'd0, cmdValid}, 40'd0);
    check("rst_cmdAddr",  {16'd0, cmdAddr},  40'd0);
    check("rst_cmdLen",   {24'd0, cmdLen},   40'd0);
    check("rst_errValid", {39'd0, errValid}, 40'd0);
    check("rst_errCode",  {37'd0, errCode},  40'd0);
    check("rst_busy",     {39'd0, busy},     40'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Valid frame, reader already ready: 1-cycle latency then single-cycle accept.
    cmdReady = 1'b1;
    cmdQ.push_back('{addr: 24'h000100, len: 16'h0010});
    sendByte(8'h52); sendByte(8'h00); sendByte(8'h01);
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h10);
    sendRaw(8'h43);
    check("t1_latency_valid", {39'd0, cmdValid}, 40'd1);
    @(posedge clk); #1;
    check("t1_valid_dropped", {39'd0, cmdValid}, 40'd0);
    check("t1_busy_dropped",  {39'd0, busy},     40'd0);
    dropByte();

    // Bad checksum.
    errQ.push_back(3'd2);
    sendFrame(56'h52_00_01_00_00_10_44);
    check("t2_no_cmd", {39'd0, cmdValid}, 40'd0);
    check("t2_idle",   {39'd0, busy},     40'd0);
    check("t2_code_held", {37'd0, errCode}, 40'd2);

    // Bad opcode, then all-ones address (XOR of 52 FF FF FF 00 01 is AC).
    errQ.push_back(3'd1);
    sendByte(8'h41);
    check("t3_idle_after_op", {39'd0, busy}, 40'd0);
    cmdQ.push_back('{addr: 24'hFFFFFF, len: 16'h0001});
    sendFrame(56'h52_FF_FF_FF_00_01_AC);
    waitIdle("t3_idle");

    // Zero length with a correct checksum (52^12^34^56 = 22).
    errQ.push_back(3'd4);
    sendFrame(56'h52_12_34_56_00_00_22);
    check("t4_no_cmd", {39'd0, cmdValid}, 40'd0);
    check("t4_idle",   {39'd0, busy},     40'd0);

    // Timeout: 100 idle cycles after the last byte.
    errQ.push_back(3'd3);
    sendByte(8'h52);
    sendRaw(8'h12);
    n = 0;
    while (!errValid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_timeout_delay_in_window", {39'd0, (n >= 99 && n <= 101)}, 40'd1);
    check("t5_idle", {39'd0, busy}, 40'd0);
    byteReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmdQ.push_back('{addr: 24'hABCDEF, len: 16'h0100});
    sendFrame(56'h52_AB_CD_EF_01_00_DA);
    waitIdle("t5_recover_idle");

    // Stalled reader with an overrun byte.
    cmdReady = 1'b0;
    cmdQ.push_back('{addr: 24'h123456, len: 16'h0300});
    sendFrame(56'h52_12_34_56_03_00_21);
    repeat (500) @(posedge clk);
    #1;
    check("t6_still_valid", {39'd0, cmdValid}, 40'd1);
    errQ.push_back(3'd5);
    sendByte(8'h00);
    check("t6_valid_kept", {39'd0, cmdValid}, 40'd1);
    check("t6_addr_len_stable", {cmdAddr, cmdLen}, {24'h123456, 16'h0300});
    cmdReady = 1'b1;
    @(posedge clk); #1;
    check("t6_valid_low_after_accept", {39'd0, cmdValid}, 40'd0);

    // Reset with byteReady held high: no byte after release.
    reset = 1'b1;
    @(posedge clk); #1;
    dataIn    = 8'h41;
    byteReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t7_no_byte_busy", {39'd0, busy},     40'd0);
    check("t7_no_byte_err",  {39'd0, errValid}, 40'd0);
    byteReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-ADDR: back to IDLE silently, then a clean frame.
    sendByte(8'h52);
    sendByte(8'h12);
    check("t7_mid_addr_busy", {39'd0, busy}, 40'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t7_reset_idle", {39'd0, busy}, 40'd0);
    cmdQ.push_back('{addr: 24'h000100, len: 16'h0010});
    sendFrame(56'h52_00_01_00_00_10_43);
    waitIdle("t7_final_idle");

    repeat (5) @(posedge clk);
    #1;
    check("errQ_drained", 40'(errQ.size()), 40'd0);
    check("cmdQ_drained", 40'(cmdQ.size()), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
